pc_sequencer: RTL and testbench

Parametrised program-counter unit with a built-in multicycle phase counter for the RISC-V multicycle datapath. It generates the `estado` phase sequence consumed by the control path. It updates the PC exactly once per instruction, on leaving the last phase, choosing among sequential, conditional-branch, register-jump and trap targets. It also provides the link value and the address of the instruction in flight.

---
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle phase counter and PC unit; optional misalignment trap via PC_MISALIGN_TRAP_EN
module pc_sequencer #(
  parameter int XLEN       = 32,
  parameter int IMM_W      = 12,
  parameter int PC_STEP    = 1,
  parameter int NUM_STATES = 5,
  parameter int STATE_W    = 3,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         pcsrc,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [XLEN-1:0]    rs1,
  output logic [STATE_W-1:0] estado,
  output logic [XLEN-1:0]    PC,
  output logic [XLEN-1:0]    pc_plus,
  output logic [XLEN-1:0]    pc_prev,
  output logic               pc_we,
  output logic               misalign
);

  localparam logic [STATE_W-1:0] LAST_PHASE = STATE_W'(NUM_STATES - 1);
  localparam logic [XLEN-1:0]    STEP_X     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0]    LSB_ONE    = XLEN'(1);

  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] branch_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            mis_flag;
  logic            last_phase;

  assign imm_ext    = {{(XLEN-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign branch_sum = PC + imm_ext;
  assign jalr_sum   = rs1 + imm_ext;
  assign pc_plus    = PC + STEP_X;
  assign last_phase = (estado == LAST_PHASE);

  // Raw next-PC target selected by pcsrc; jalr always drops bit 0
  always_comb begin
    target = pc_plus;
    case (pcsrc)
      2'b00:   target = pc_plus;
      2'b01:   target = branch_taken ? branch_sum : pc_plus;
      2'b10:   target = jalr_sum & ~LSB_ONE;
      default: target = TRAP_VEC;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [XLEN-1:0] STEP_MASK = XLEN'(PC_STEP - 1);
  logic align_chk;

  // Computed targets (taken branch, jalr) that are not step-aligned divert to the trap vector
  always_comb begin
    align_chk = (pcsrc == 2'b10) || ((pcsrc == 2'b01) && branch_taken);
    mis_flag  = align_chk && ((target & STEP_MASK) != '0);
    next_pc   = mis_flag ? TRAP_VEC : target;
  end
`else
  // Without the trap option every target is loaded as computed
  always_comb begin
    next_pc  = target;
    mis_flag = 1'b0;
  end
`endif

  // Phase counter and PC registers; the PC only moves when leaving the last phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= '0;
      PC       <= RESET_PC;
      pc_prev  <= RESET_PC;
      pc_we    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc_we    <= 1'b0;
      misalign <= 1'b0;
      if (!stall) begin
        if (last_phase) begin
          estado   <= '0;
          pc_prev  <= PC;
          PC       <= next_pc;
          pc_we    <= 1'b1;
          misalign <= mis_flag;
        end else begin
          estado <= estado + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam int          NS   = 5;
  localparam int          STEP = 4;
  localparam logic [31:0] TV   = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic        branch_taken = 1'b0;
  logic [11:0] immediate = '0;
  logic [31:0] rs1 = '0;
  logic [2:0]  estado;
  logic [31:0] pc, pc_plus, pc_prev;
  logic        pc_we, misalign;

  pc_sequencer #(
    .XLEN(32), .IMM_W(12), .PC_STEP(STEP), .NUM_STATES(NS), .STATE_W(3),
    .RESET_PC(32'h0), .TRAP_VEC(TV)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc),
    .branch_taken(branch_taken), .immediate(immediate), .rs1(rs1),
    .estado(estado), .PC(pc), .pc_plus(pc_plus), .pc_prev(pc_prev),
    .pc_we(pc_we), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] prev;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int          m_phase = 0;
  logic [31:0] m_pc    = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every pc_we pulse must match the oldest expected update
  always @(negedge clk) begin
    if (!reset) begin
      if (pc_we) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL pc_we_spurious actual=1 required=0 at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_pc", pc, e.pc);
          chk("sb_pc_prev", pc_prev, e.prev);
          chk("sb_misalign", {31'b0, misalign}, {31'b0, e.mis});
        end
      end else if (misalign) begin
        total++; bad++;
        $display("FAIL misalign_without_pc_we actual=1 required=0 at %0t", $time);
      end
    end
  end

  // One cycle of stimulus, issued at a falling edge; the reference model advances alongside
  task automatic step(input logic st, input logic [1:0] src, input logic bt,
                      input logic [11:0] imm, input logic [31:0] r1);
    logic [31:0] t;
    logic        mis;
    int          simm;
    chk("estado", {29'b0, estado}, 32'(m_phase));
    chk("pc_plus", pc_plus, m_pc + STEP);
    stall = st; pcsrc = src; branch_taken = bt; immediate = imm; rs1 = r1;
    if (!st) begin
      if (m_phase == NS - 1) begin
        simm = $signed(imm);
        mis  = 1'b0;
        case (src)
          2'd0: t = m_pc + STEP;
          2'd1: t = bt ? m_pc + simm : m_pc + STEP;
          2'd2: t = (r1 + simm) & 32'hFFFF_FFFE;
          default: t = TV;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        if ((src == 2'd2 || (src == 2'd1 && bt)) && (t % STEP) != 0) begin
          t   = TV;
          mis = 1'b1;
        end
`endif
        q.push_back('{t, m_pc, mis});
        m_pc    = t;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    @(negedge clk);
  endtask

  // A whole instruction from phase 0; inputs in earlier phases are random noise
  task automatic instr(input logic [1:0] src, input logic bt, input logic [11:0] imm,
                       input logic [31:0] r1);
    for (int i = 0; i < NS - 1; i++)
      step(1'b0, 2'($urandom), 1'($urandom), 12'($urandom), $urandom);
    step(1'b0, src, bt, imm, r1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    stall = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_prev", pc_prev, 32'h0);
    chk("rst_estado", {29'b0, estado}, 32'h0);
    chk("rst_pc_we", {31'b0, pc_we}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    @(negedge clk);
    chk("rst_stall_ignored", {29'b0, estado}, 32'h0);
    reset = 1'b0;
    stall = 1'b0;

    // sequential run 0 -> 4 -> 8 -> 12
    for (int k = 0; k < 3; k++) instr(2'b00, 1'b0, 12'h0, 32'h0);
    chk("seq3_pc", pc, 32'd12);

    // branch taken / not taken from 0x20
    instr(2'b10, 1'b0, 12'h000, 32'h20);
    instr(2'b01, 1'b1, 12'hFF8, $urandom);
    instr(2'b10, 1'b0, 12'h000, 32'h20);
    instr(2'b01, 1'b0, 12'hFF8, $urandom);

    // jalr clears bit 0, then trap
    instr(2'b10, 1'b0, 12'h004, 32'h1001);
    instr(2'b11, 1'b0, 12'h0, 32'h0);

    // stall held in the last phase; inputs during stall must be ignored
    for (int i = 0; i < NS - 1; i++) step(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11, 1'b1, 12'h7F0, 32'hDEAD_BEEF);
      chk("stall_pc_hold", pc, m_pc);
    end
    step(1'b0, 2'b01, 1'b1, 12'h010, 32'h0);

    // asynchronous reset mid-instruction at phase 2, PC=0x40
    instr(2'b10, 1'b0, 12'h000, 32'h40);
    step(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    step(1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    chk("pre_reset_pc", pc, 32'h40);
    #2 reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_prev", pc_prev, 32'h0);
    chk("async_estado", {29'b0, estado}, 32'h0);
    @(negedge clk);
    reset   = 1'b0;
    m_pc    = 32'h0;
    m_phase = 0;

    // PC wraps from the top of the address space
    instr(2'b10, 1'b0, 12'h000, 32'hFFFF_FFFC);
    instr(2'b00, 1'b0, 12'h0, 32'h0);

    // misaligned branch target 0x22
    instr(2'b10, 1'b0, 12'h000, 32'h20);
    instr(2'b01, 1'b1, 12'h002, 32'h0);

    // randomized traffic with random stalls
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 4) == 0), 2'($urandom), 1'($urandom), 12'($urandom), $urandom);

    step(1'b1, 2'b00, 1'b0, 12'h0, 32'h0);
    step(1'b1, 2'b00, 1'b0, 12'h0, 32'h0);
    #1;
    chk("sb_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
